clock_divider_multi: RTL



---
 rtl/clock_divider_multi.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent power-of-two dividers of clk_in.
// Each channel produces a one-cycle tick or a ~50% square wave, plus a wrap
// pulse at the start of each period. A global sync strobe restarts every
// enabled channel at count 1 so that all channels phase-align.
module clock_divider_multi #(
  parameter int NUM_CH        = 4,
  parameter int MAX_SHIFT     = 29,
  parameter int DEFAULT_SHIFT = 8,
  parameter int DEFAULT_MODE  = 0
) (
  input  logic                                        clk_in,
  input  logic                                        rst_n,
  input  logic [NUM_CH-1:0]                           ch_en,
  input  logic                                        sync,
  input  logic                                        cfg_valid,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]              cfg_shift,
  input  logic                                        cfg_mode,
  output logic [NUM_CH-1:0]                           clk_out,
  output logic [NUM_CH-1:0]                           wrap
);

  localparam int CNT_W = MAX_SHIFT + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SH_W  = $clog2(MAX_SHIFT + 1);

  localparam logic [SH_W-1:0]  MAX_SH   = SH_W'(MAX_SHIFT);
  localparam logic [SH_W-1:0]  DEF_SH   = SH_W'(DEFAULT_SHIFT);
  localparam logic             DEF_MODE = (DEFAULT_MODE != 0);
  // One extra bit so NUM_CH itself is representable for the range check.
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]  r_count [NUM_CH];
  logic [SH_W-1:0]   r_shift [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_clk_out;
  logic [NUM_CH-1:0] r_wrap;

  logic [CNT_W-1:0]  w_period    [NUM_CH];
  logic [CNT_W-1:0]  w_half      [NUM_CH];
  logic [CNT_W-1:0]  w_count_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_clk_nxt;
  logic [NUM_CH-1:0] w_wrap_nxt;
  logic              w_cfg_hit;
  logic [SH_W-1:0]   w_cfg_shift;

  assign w_cfg_hit   = cfg_valid && ({1'b0, cfg_ch} < CH_LIMIT);
  assign w_cfg_shift = (cfg_shift > MAX_SH) ? MAX_SH : cfg_shift;

  // Next count per channel (disable > sync > wrap > increment) and the
  // outputs derived from that next count, so the registered outputs line up
  // with the registered count.
  always_comb begin
    w_period    = '{default: '0};
    w_half      = '{default: '0};
    w_count_nxt = '{default: '0};
    w_clk_nxt   = '0;
    w_wrap_nxt  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_period[i] = ONE << r_shift[i];
      w_half[i]   = w_period[i] >> 1;
      if (w_half[i] == '0) begin
        w_half[i] = ONE;
      end
      // ">=" rather than "==" lets a retarget to a shorter period wrap
      // on the next edge instead of running the counter off the end.
      if (!ch_en[i]) begin
        w_count_nxt[i] = '0;
      end else if (sync) begin
        w_count_nxt[i] = ONE;
      end else if (r_count[i] >= w_period[i]) begin
        w_count_nxt[i] = ONE;
      end else begin
        w_count_nxt[i] = r_count[i] + ONE;
      end
      w_wrap_nxt[i] = (w_count_nxt[i] == ONE);
      if (r_mode[i]) begin
        w_clk_nxt[i] = (w_count_nxt[i] != '0) && (w_count_nxt[i] <= w_half[i]);
      end else begin
        w_clk_nxt[i] = w_wrap_nxt[i];
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_count[i] <= '0;
      end
      r_clk_out <= '0;
      r_wrap    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_count[i] <= w_count_nxt[i];
      end
      r_clk_out <= w_clk_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  // Per-channel configuration; written regardless of ch_en, takes effect
  // on the edge after the write.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_shift[i] <= DEF_SH;
      end
      r_mode <= {NUM_CH{DEF_MODE}};
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_cfg_hit && (cfg_ch == CH_W'(i))) begin
          r_shift[i] <= w_cfg_shift;
          r_mode[i]  <= cfg_mode;
        end
      end
    end
  end

  assign clk_out = r_clk_out;
  assign wrap    = r_wrap;

endmodule
